// File: rtl/ahb_pkg.sv
// Shared AHB-lite definitions for the bus mux and its default slave.
// Holds the HTRANS and HRESP encodings, the default-slave state encoding
// and a helper that flags NONSEQ/SEQ transfers.
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

  // True for transfers that need a response (NONSEQ or SEQ).
  function automatic logic is_xfer(input logic [1:0] t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction
endpackage

// File: rtl/ahb_default_slave.sv
// Internal default slave that answers transfers to unmapped addresses.
// IDLE/BUSY get a zero-wait OKAY; NONSEQ/SEQ get the two-cycle ERROR
// response (HREADY low + ERROR, then HREADY high + ERROR).
// Ports:
//   clk, rst_n   bus clock, async active-low reset
//   sel          address phase targets unmapped space
//   htrans       master transfer type
//   hready       muxed bus HREADY (address phase accepted when high)
//   hready_out   default slave HREADYOUT (registered)
//   hresp        default slave HRESP (registered)
//   hrdata       constant DEF_RDATA
module ahb_default_slave
  import ahb_pkg::*;
#(
  parameter logic [31:0] DEF_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic [1:0]  htrans,
  input  logic        hready,
  output logic        hready_out,
  output logic        hresp,
  output logic [31:0] hrdata
);
  ds_state_e state;
  logic      start;

  // A new erroring transfer is accepted into the data phase this cycle.
  assign start  = sel && is_xfer(htrans) && hready;
  assign hrdata = DEF_RDATA;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= DS_IDLE;
      hready_out <= 1'b1;
      hresp      <= HRESP_OKAY;
    end else begin
      unique case (state)
        DS_IDLE, DS_ERR2: begin
          if (start) begin
            state      <= DS_ERR1;
            hready_out <= 1'b0;
            hresp      <= HRESP_ERROR;
          end else begin
            state      <= DS_IDLE;
            hready_out <= 1'b1;
            hresp      <= HRESP_OKAY;
          end
        end
        DS_ERR1: begin
          state      <= DS_ERR2;
          hready_out <= 1'b1;
          hresp      <= HRESP_ERROR;
        end
        default: begin
          state      <= DS_IDLE;
          hready_out <= 1'b1;
          hresp      <= HRESP_OKAY;
        end
      endcase
    end
  end
endmodule

// File: rtl/ahblite_bus_mux_n.sv
// AHB-lite bus: one master fanned out to NUM_S slaves.
// Address-phase decode against parameter windows (lowest index wins on
// overlap) drives one-hot HSEL_S; a data-phase select register routes
// HREADY/HRDATA/HRESP back from the active slave or the internal default
// slave (unmapped space).
// Optional macro AHB_BUS_ERRLOG_EN adds an error-address capture block
// (ERR_ADDR, ERR_VALID, ERR_CLR).
// Ports:
//   HCLK, HRESETn     bus clock, async active-low reset (release is
//                     expected synchronous to HCLK)
//   HADDR, HTRANS     master address phase
//   HREADY/HRDATA/HRESP  muxed response to master (HREADY also to slaves)
//   HSEL_S            one-hot slave selects
//   HREADY_S/HRDATA_S/HRESP_S  slave responses, slave i at index i
module ahblite_bus_mux_n
  import ahb_pkg::*;
#(
  parameter int                   NUM_S     = 6,
  parameter logic [32*NUM_S-1:0]  SLV_BASE  = {NUM_S{32'h0}},
  parameter logic [32*NUM_S-1:0]  SLV_MASK  = {NUM_S{32'hFF00_0000}},
  parameter logic [31:0]          DEF_RDATA = 32'hDEAD_BEEF
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [31:0]          HADDR,
  input  logic [1:0]           HTRANS,
  output logic                 HREADY,
  output logic [31:0]          HRDATA,
  output logic                 HRESP,
  output logic [NUM_S-1:0]     HSEL_S,
  input  logic [NUM_S-1:0]     HREADY_S,
  input  logic [32*NUM_S-1:0]  HRDATA_S,
  input  logic [NUM_S-1:0]     HRESP_S
`ifdef AHB_BUS_ERRLOG_EN
  ,
  output logic [31:0]          ERR_ADDR,
  output logic                 ERR_VALID,
  input  logic                 ERR_CLR
`endif
);
  localparam logic [NUM_S-1:0][31:0] BASE    = SLV_BASE;
  localparam logic [NUM_S-1:0][31:0] MASK    = SLV_MASK;
  localparam logic [NUM_S:0]         SEL_DEF = {1'b1, {NUM_S{1'b0}}};

  logic [NUM_S-1:0][31:0] rdata_s;
  logic [NUM_S-1:0]       hit;
  logic [NUM_S-1:0]       hit_oh;
  logic                   def_hit;
  logic [NUM_S:0]         sel_q;
  logic                   ds_ready, ds_resp;
  logic [31:0]            ds_rdata;

  assign rdata_s = HRDATA_S;

  // ---- address decode ----
  for (genvar i = 0; i < NUM_S; i++) begin : g_dec
    assign hit[i] = ((HADDR & MASK[i]) == BASE[i]);
  end

  // Isolate lowest set bit: lowest index wins on overlapping windows.
  assign hit_oh  = hit & (~hit + NUM_S'(1));
  assign def_hit = ~|hit;
  assign HSEL_S  = hit_oh;

  // ---- data-phase select ----
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)    sel_q <= SEL_DEF;
    else if (HREADY) sel_q <= {def_hit, hit_oh};
  end

  // ---- default slave ----
  ahb_default_slave #(.DEF_RDATA(DEF_RDATA)) u_def (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .sel       (def_hit),
    .htrans    (HTRANS),
    .hready    (HREADY),
    .hready_out(ds_ready),
    .hresp     (ds_resp),
    .hrdata    (ds_rdata)
  );

  // ---- response mux (AND-OR over one-hot sel_q) ----
  always_comb begin
    HREADY = 1'b0;
    HRESP  = HRESP_OKAY;
    HRDATA = '0;
    for (int i = 0; i < NUM_S; i++) begin
      HREADY = HREADY | (sel_q[i] & HREADY_S[i]);
      HRESP  = HRESP  | (sel_q[i] & HRESP_S[i]);
      HRDATA = HRDATA | ({32{sel_q[i]}} & rdata_s[i]);
    end
    HREADY = HREADY | (sel_q[NUM_S] & ds_ready);
    HRESP  = HRESP  | (sel_q[NUM_S] & ds_resp);
    HRDATA = HRDATA | ({32{sel_q[NUM_S]}} & ds_rdata);
  end

  // ---- optional error capture ----
`ifdef AHB_BUS_ERRLOG_EN
  logic [31:0] addr_q;

  // Data-phase address, advanced in lock-step with sel_q.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)    addr_q <= '0;
    else if (HREADY) addr_q <= HADDR;
  end

  // First error wins; a clear in the same cycle as a new error lets the
  // new error be captured.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ERR_ADDR  <= '0;
      ERR_VALID <= 1'b0;
    end else if ((HRESP == HRESP_ERROR) && (!ERR_VALID || ERR_CLR)) begin
      ERR_ADDR  <= addr_q;
      ERR_VALID <= 1'b1;
    end else if (ERR_CLR) begin
      ERR_VALID <= 1'b0;
    end
  end
`else
  // No error capture state in this build.
`endif
endmodule

// File: tb/tb_ahblite_bus_mux_n.sv
// Directed bench for ahblite_bus_mux_n. Map: slaves at 0x00/0x20/0x40/
// 0x48/0x4C/0x50 << 24, slave 2 widened to mask 0xF000_0000 so it
// shadows slaves 3 and 4 (overlap case). Slave i returns 0xA000_000i.
module tb_ahblite_bus_mux_n;
  localparam int NS = 6;

  logic            HCLK = 1'b0;
  logic            HRESETn;
  logic [31:0]     HADDR;
  logic [1:0]      HTRANS;
  logic            HREADY;
  logic [31:0]     HRDATA;
  logic            HRESP;
  logic [NS-1:0]   HSEL_S;
  logic [NS-1:0]   HREADY_S;
  logic [32*NS-1:0] HRDATA_S;
  logic [NS-1:0]   HRESP_S;
`ifdef AHB_BUS_ERRLOG_EN
  logic [31:0]     ERR_ADDR;
  logic            ERR_VALID;
  logic            ERR_CLR;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  always #5 HCLK = ~HCLK;

  ahblite_bus_mux_n #(
    .NUM_S    (NS),
    .SLV_BASE ({32'h5000_0000, 32'h4C00_0000, 32'h4800_0000,
                32'h4000_0000, 32'h2000_0000, 32'h0000_0000}),
    .SLV_MASK ({32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000,
                32'hF000_0000, 32'hFF00_0000, 32'hFF00_0000}),
    .DEF_RDATA(32'hDEAD_BEEF)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .HADDR   (HADDR),
    .HTRANS  (HTRANS),
    .HREADY  (HREADY),
    .HRDATA  (HRDATA),
    .HRESP   (HRESP),
    .HSEL_S  (HSEL_S),
    .HREADY_S(HREADY_S),
    .HRDATA_S(HRDATA_S),
    .HRESP_S (HRESP_S)
`ifdef AHB_BUS_ERRLOG_EN
    ,
    .ERR_ADDR (ERR_ADDR),
    .ERR_VALID(ERR_VALID),
    .ERR_CLR  (ERR_CLR)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    HRESETn  = 1'b1;
    HADDR    = 32'h2000_0010;
    HTRANS   = 2'b00;
    HREADY_S = '1;
    HRESP_S  = '0;
    for (int i = 0; i < NS; i++) HRDATA_S[32*i +: 32] = 32'hA000_0000 + 32'(i);
`ifdef AHB_BUS_ERRLOG_EN
    ERR_CLR = 1'b0;
`endif
    #1 HRESETn = 1'b0;
    #2;
    // reset state; HSEL follows HADDR during reset
    chk("rst_hready", 32'(HREADY), 32'h1);
    chk("rst_hresp",  32'(HRESP),  32'h0);
    chk("rst_hrdata", HRDATA,      32'hDEAD_BEEF);
    chk("rst_hsel",   32'(HSEL_S), 32'h02);
`ifdef AHB_BUS_ERRLOG_EN
    chk("rst_err_valid", 32'(ERR_VALID), 32'h0);
    chk("rst_err_addr",  ERR_ADDR,       32'h0);
`endif
    #9 HRESETn = 1'b1;

    // NONSEQ to slave 1
    tick();
    HTRANS = 2'b10; HADDR = 32'h2000_0010;
    #1 chk("s1_hsel", 32'(HSEL_S), 32'h02);
    chk("s1_addr_hready", 32'(HREADY), 32'h1);

    // slave 1 waits 3 cycles; next address (slave 0) must not register
    tick();
    HREADY_S[1] = 1'b0; HADDR = 32'h0000_0100;
    #1 chk("wait1_hready", 32'(HREADY), 32'h0);
    chk("s0_hsel", 32'(HSEL_S), 32'h01);
    tick();
    #1 chk("wait2_hready", 32'(HREADY), 32'h0);
    tick();
    #1 chk("wait3_hready", 32'(HREADY), 32'h0);
    tick();
    HREADY_S[1] = 1'b1;
    #1 chk("s1_hready", 32'(HREADY), 32'h1);
    chk("s1_hrdata", HRDATA, 32'hA000_0001);
    chk("s1_hresp",  32'(HRESP), 32'h0);

    // slave 0 data phase with slave ERROR passed through; IDLE to unmapped next
    tick();
    HTRANS = 2'b00; HADDR = 32'h9000_0004; HRESP_S[0] = 1'b1;
    #1 chk("s0_hrdata", HRDATA, 32'hA000_0000);
    chk("s0_hresp_pass", 32'(HRESP), 32'h1);
    chk("unmap_hsel", 32'(HSEL_S), 32'h00);

    // unmapped IDLE data phase: zero-wait OKAY; present unmapped NONSEQ
    tick();
    HRESP_S[0] = 1'b0; HTRANS = 2'b10;
`ifdef AHB_BUS_ERRLOG_EN
    chk("log_slave_valid", 32'(ERR_VALID), 32'h1);
    chk("log_slave_addr",  ERR_ADDR,       32'h0000_0100);
    ERR_CLR = 1'b1;
`endif
    #1 chk("idle_unmap_hready", 32'(HREADY), 32'h1);
    chk("idle_unmap_hresp",  32'(HRESP), 32'h0);
    chk("idle_unmap_hrdata", HRDATA, 32'hDEAD_BEEF);

    // ERR1, with a back-to-back unmapped NONSEQ waiting
    tick();
    HADDR = 32'h9000_0008;
`ifdef AHB_BUS_ERRLOG_EN
    ERR_CLR = 1'b0;
    chk("log_clr_valid", 32'(ERR_VALID), 32'h0);
`endif
    #1 chk("err1a_hready", 32'(HREADY), 32'h0);
    chk("err1a_hresp", 32'(HRESP), 32'h1);

    tick();
    #1 chk("err2a_hready", 32'(HREADY), 32'h1);
    chk("err2a_hresp",  32'(HRESP), 32'h1);
    chk("err2a_hrdata", HRDATA, 32'hDEAD_BEEF);
`ifdef AHB_BUS_ERRLOG_EN
    chk("log_first_addr",  ERR_ADDR, 32'h9000_0004);
    chk("log_first_valid", 32'(ERR_VALID), 32'h1);
`endif

    // second error pair from the back-to-back transfer
    tick();
    HTRANS = 2'b00;
    #1 chk("err1b_hready", 32'(HREADY), 32'h0);
    chk("err1b_hresp", 32'(HRESP), 32'h1);
    tick();
    #1 chk("err2b_hready", 32'(HREADY), 32'h1);
    chk("err2b_hresp", 32'(HRESP), 32'h1);
`ifdef AHB_BUS_ERRLOG_EN
    chk("log_hold_addr", ERR_ADDR, 32'h9000_0004);
`endif

    // back to IDLE; overlap access 0x4800_0000 -> slave 2
    tick();
    HTRANS = 2'b10; HADDR = 32'h4800_0000;
`ifdef AHB_BUS_ERRLOG_EN
    ERR_CLR = 1'b1;
`endif
    #1 chk("idle_hready", 32'(HREADY), 32'h1);
    chk("idle_hresp",   32'(HRESP), 32'h0);
    chk("overlap_hsel", 32'(HSEL_S), 32'h04);

    // slave 2 data phase; boundary address FFFF_FFFC unmapped
    tick();
    HADDR = 32'hFFFF_FFFC;
`ifdef AHB_BUS_ERRLOG_EN
    ERR_CLR = 1'b0;
`endif
    #1 chk("overlap_hrdata", HRDATA, 32'hA000_0002);
    chk("top_hsel", 32'(HSEL_S), 32'h00);
`ifdef AHB_BUS_ERRLOG_EN
    chk("log_clr2_valid", 32'(ERR_VALID), 32'h0);
`endif

    tick();
    HTRANS = 2'b00;
    #1 chk("top_err1_hready", 32'(HREADY), 32'h0);
    chk("top_err1_hresp", 32'(HRESP), 32'h1);

    tick();
    HTRANS = 2'b10; HADDR = 32'h9000_0000;
    #1 chk("top_err2_hresp", 32'(HRESP), 32'h1);
`ifdef AHB_BUS_ERRLOG_EN
    chk("log_new_addr",  ERR_ADDR, 32'hFFFF_FFFC);
    chk("log_new_valid", 32'(ERR_VALID), 32'h1);
`endif

    // reset asserted during ERR1: outputs recover asynchronously
    tick();
    #1 chk("pre_rst_err1_hready", 32'(HREADY), 32'h0);
    HRESETn = 1'b0; HTRANS = 2'b00;
    #1 chk("async_rst_hready", 32'(HREADY), 32'h1);
    chk("async_rst_hresp",  32'(HRESP), 32'h0);
    chk("async_rst_hrdata", HRDATA, 32'hDEAD_BEEF);
`ifdef AHB_BUS_ERRLOG_EN
    chk("async_rst_err_valid", 32'(ERR_VALID), 32'h0);
`endif
    #2 HRESETn = 1'b1;
    HTRANS = 2'b10; HADDR = 32'h5000_0000;
    #1 chk("post_rst_hsel", 32'(HSEL_S), 32'h20);
    chk("post_rst_hready", 32'(HREADY), 32'h1);

    tick();
    HTRANS = 2'b00;
    #1 chk("post_rst_hrdata", HRDATA, 32'hA000_0005);
    chk("post_rst_hresp",  32'(HRESP), 32'h0);
    chk("post_rst_hready2", 32'(HREADY), 32'h1);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
